// File: rtl/instr_pkg.sv
// Shared types and default widths for the instruction-execute block.
package instr_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int PC_W_DEF   = 8;

  typedef enum logic [2:0] {
    OP_ADDI = 3'd0,
    OP_SUBI = 3'd1,
    OP_ANDI = 3'd2,
    OP_XORI = 3'd3,
    OP_JMP  = 3'd4,
    OP_JMPC = 3'd5,
    OP_CALL = 3'd6,
    OP_ILL  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    REG0 = 2'd0,
    REG1 = 2'd1,
    REG2 = 2'd2,
    REG3 = 2'd3
  } reg_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/instr_exec_if.sv
// Instruction-in / result-out handshake bundle plus architectural status (pc, carry).
interface instr_exec_if
  import instr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  op_t               in_op;
  reg_t              in_reg;
  logic [DATA_W-1:0] in_imm;

  logic              out_valid;
  logic              out_ready;
  reg_t              out_reg;
  logic [DATA_W-1:0] out_data;
  logic              err;

  logic [PC_W-1:0]   pc;
  logic              carry;

  // Producer/consumer side (drives instructions, accepts results).
  modport master (
    output in_valid, in_op, in_reg, in_imm, out_ready,
    input  in_ready, out_valid, out_reg, out_data, err, pc, carry
  );

  // Execute unit side.
  modport slave (
    input  in_valid, in_op, in_reg, in_imm, out_ready,
    output in_ready, out_valid, out_reg, out_data, err, pc, carry
  );

endinterface

// File: rtl/instr_alu.sv
// Combinational execute stage: result value, next carry and next pc for one instruction.
module instr_alu
  import instr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  op_t               op_i,
  input  logic [DATA_W-1:0] operand_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              carry_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              reg_we_o,
  output logic              err_o
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   pc_tgt;

  // Decode the op; result_o is what the block reports on out_data.
  always_comb begin
    sum    = {1'b0, operand_i} + {1'b0, imm_i};
    diff   = {1'b0, operand_i} - {1'b0, imm_i};
    pc_inc = pc_i + PC_W'(1);
    pc_tgt = PC_W'(imm_i);
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    result_o = '0;
    carry_o  = carry_i;
    pc_o     = pc_inc;
    reg_we_o = 1'b0;
    err_o    = 1'b0;
    case (op_i)
      OP_ADDI: begin
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
        reg_we_o = 1'b1;
      end
      OP_SUBI: begin
        result_o = diff[DATA_W-1:0];
        carry_o  = diff[DATA_W];      // borrow out == operand < imm
        reg_we_o = 1'b1;
      end
      OP_ANDI: begin
        result_o = operand_i & imm_i;
        reg_we_o = 1'b1;
      end
      OP_XORI: begin
        result_o = operand_i ^ imm_i;
        reg_we_o = 1'b1;
      end
      OP_JMP: begin
        pc_o     = pc_tgt;
        result_o = DATA_W'(pc_tgt);
      end
      OP_JMPC: begin
        pc_o     = carry_i ? pc_tgt : pc_inc;
        result_o = DATA_W'(carry_i ? pc_tgt : pc_inc);
      end
      OP_CALL: begin
        result_o = DATA_W'(pc_inc);   // return address goes to REG3
        pc_o     = pc_tgt;
        reg_we_o = 1'b1;
      end
      default: begin
        pc_o  = pc_i;
        err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_exec.sv
// Three-state execute unit: accept one instruction, execute it, hold the result until taken.
module instr_exec
  import instr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  instr_exec_if.slave bus
);

  state_t            state_q, state_d;
  logic              ready_en_q;
  op_t               op_q;
  reg_t              reg_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] regs_q [4];
  logic [PC_W-1:0]   pc_q;
  logic              carry_q;
  reg_t              out_reg_q;
  logic [DATA_W-1:0] out_data_q;
  logic              err_q;

  logic              accept;
  reg_t              wr_reg;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic [PC_W-1:0]   alu_pc;
  logic              alu_we;
  logic              alu_err;

  assign accept = bus.in_valid && bus.in_ready;
  assign wr_reg = (op_q == OP_CALL) ? REG3 : reg_q;

  instr_alu #(.DATA_W(DATA_W), .PC_W(PC_W)) u_alu (
    .op_i      (op_q),
    .operand_i (regs_q[reg_q]),
    .imm_i     (imm_q),
    .carry_i   (carry_q),
    .pc_i      (pc_q),
    .result_o  (alu_result),
    .carry_o   (alu_carry),
    .pc_o      (alu_pc),
    .reg_we_o  (alu_we),
    .err_o     (alu_err)
  );

  // State register; ready_en_q holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept)        state_d = S_EXEC;
      S_EXEC:                     state_d = S_RESP;
      S_RESP:  if (bus.out_ready) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    bus.in_ready  = ready_en_q && (state_q == S_IDLE);
    bus.out_valid = (state_q == S_RESP);
  end

  // Datapath: latch on accept, commit architectural state and result on the EXEC edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_ADDI;
      reg_q      <= REG0;
      imm_q      <= '0;
      pc_q       <= '0;
      carry_q    <= 1'b0;
      out_reg_q  <= REG0;
      out_data_q <= '0;
      err_q      <= 1'b0;
      // NOTE: the register file is architectural state that must read zero after reset, so it is reset here.
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.in_op;
        reg_q <= bus.in_reg;
        imm_q <= bus.in_imm;
      end
      if (state_q == S_EXEC) begin
        if (alu_we) regs_q[wr_reg] <= alu_result;
        pc_q       <= alu_pc;
        carry_q    <= alu_carry;
        out_reg_q  <= wr_reg;
        out_data_q <= alu_result;
        err_q      <= alu_err;
      end
    end
  end

  assign bus.out_reg  = out_reg_q;
  assign bus.out_data = out_data_q;
  assign bus.err      = err_q;
  assign bus.pc       = pc_q;
  assign bus.carry    = carry_q;

endmodule

// File: tb/tb_instr_exec.sv
// Self-checking bench for instr_exec: directed scenarios plus randomized run against a behavioural model.
module tb_instr_exec;
  import instr_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  // Behavioural model state (plain integers).
  int   m_regs [4];
  int   m_pc;
  bit   m_carry;

  instr_exec_if #(.DATA_W(8), .PC_W(8)) bus ();

  instr_exec #(.DATA_W(8), .PC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_pc    = 0;
    m_carry = 1'b0;
  endtask

  // Architectural effect of one instruction, from the op definitions.
  task automatic model_step(input int op, input int r, input int imm,
                            output int e_reg, output int e_data, output int e_err);
    int a;
    a = m_regs[r];
    e_reg = r; e_data = 0; e_err = 0;
    case (op)
      0: begin e_data = (a + imm) % 256; m_carry = (a + imm) > 255; end
      1: begin e_data = (a - imm + 256) % 256; m_carry = (a < imm); end
      2: e_data = a & imm;
      3: e_data = a ^ imm;
      4: begin m_pc = imm; e_data = m_pc; end
      5: begin m_pc = m_carry ? imm : (m_pc + 1) % 256; e_data = m_pc; end
      6: begin e_data = (m_pc + 1) % 256; m_regs[3] = e_data; m_pc = imm; e_reg = 3; end
      default: e_err = 1;
    endcase
    if (op <= 3) begin
      m_regs[r] = e_data;
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  // Issue one instruction, leave out_ready low, return when out_valid is seen (or bound expires).
  task automatic run_instr(input logic [2:0] op, input logic [1:0] r, input logic [7:0] imm,
                           output int lat, output logic [1:0] o_reg, output logic [7:0] o_data,
                           output logic o_err, output logic [7:0] o_pc, output logic o_carry);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    bus.in_op    = op_t'(op);
    bus.in_reg   = reg_t'(r);
    bus.in_imm   = imm;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    o_reg   = bus.out_reg;
    o_data  = bus.out_data;
    o_err   = bus.err;
    o_pc    = bus.pc;
    o_carry = bus.carry;
  endtask

  task automatic finish_resp();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b need 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b need 0", bus.out_valid); end
    checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL rst_pc: got %h need 00", bus.pc); end
    checks++; if (bus.carry !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL rst_flags: carry=%b err=%b need 0/0", bus.carry, bus.err); end
    checks++; if (bus.out_data !== 8'h00 || bus.out_reg !== REG0) begin errors++; $display("FAIL rst_out: data=%h reg=%0d need 00/0", bus.out_data, bus.out_reg); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready: got %b need 0 before first edge", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_first_edge_ready: got %b need 1", bus.in_ready); end
  endtask

  task automatic test_add_jmpc();
    int lat; logic [1:0] o_reg; logic [7:0] o_data, o_pc; logic o_err, o_carry;
    do_reset();
    run_instr(3'd0, 2'd1, 8'd100, lat, o_reg, o_data, o_err, o_pc, o_carry);
    checks++; if (lat !== 2) begin errors++; $display("FAIL addi1_latency: got %0d edges need 2", lat); end
    checks++; if (o_reg !== 2'd1 || o_data !== 8'd100) begin errors++; $display("FAIL addi1_result: reg=%0d data=%0d need 1/100", o_reg, o_data); end
    checks++; if (o_carry !== 1'b0 || o_pc !== 8'd1 || o_err !== 1'b0) begin errors++; $display("FAIL addi1_state: carry=%b pc=%0d err=%b need 0/1/0", o_carry, o_pc, o_err); end
    finish_resp();
    run_instr(3'd0, 2'd1, 8'd200, lat, o_reg, o_data, o_err, o_pc, o_carry);
    checks++; if (o_data !== 8'd44 || o_carry !== 1'b1) begin errors++; $display("FAIL addi2_wrap: data=%0d carry=%b need 44/1", o_data, o_carry); end
    finish_resp();
    run_instr(3'd5, 2'd2, 8'h40, lat, o_reg, o_data, o_err, o_pc, o_carry);
    checks++; if (o_data !== 8'h40 || o_pc !== 8'h40) begin errors++; $display("FAIL jmpc_taken: data=%h pc=%h need 40/40", o_data, o_pc); end
    checks++; if (o_reg !== 2'd2 || o_carry !== 1'b1) begin errors++; $display("FAIL jmpc_echo: reg=%0d carry=%b need 2/1", o_reg, o_carry); end
    finish_resp();
  endtask

  task automatic test_sub_call();
    int lat; logic [1:0] o_reg; logic [7:0] o_data, o_pc; logic o_err, o_carry;
    do_reset();
    run_instr(3'd1, 2'd0, 8'd1, lat, o_reg, o_data, o_err, o_pc, o_carry);
    checks++; if (o_data !== 8'd255 || o_carry !== 1'b1) begin errors++; $display("FAIL subi_borrow: data=%0d carry=%b need 255/1", o_data, o_carry); end
    finish_resp();
    run_instr(3'd6, 2'd1, 8'h10, lat, o_reg, o_data, o_err, o_pc, o_carry);
    checks++; if (o_reg !== 2'd3 || o_data !== 8'd2) begin errors++; $display("FAIL call_link: reg=%0d data=%0d need 3/2", o_reg, o_data); end
    checks++; if (o_pc !== 8'h10) begin errors++; $display("FAIL call_pc: got %h need 10", o_pc); end
    finish_resp();
    run_instr(3'd0, 2'd3, 8'd0, lat, o_reg, o_data, o_err, o_pc, o_carry);
    checks++; if (o_data !== 8'd2) begin errors++; $display("FAIL call_reg3: REG3 reads %0d need 2", o_data); end
    finish_resp();
  endtask

  task automatic test_wrap_illegal();
    int lat; logic [1:0] o_reg; logic [7:0] o_data, o_pc; logic o_err, o_carry;
    do_reset();
    run_instr(3'd4, 2'd0, 8'hFF, lat, o_reg, o_data, o_err, o_pc, o_carry);
    checks++; if (o_pc !== 8'hFF || o_data !== 8'hFF) begin errors++; $display("FAIL jmp_ff: pc=%h data=%h need ff/ff", o_pc, o_data); end
    finish_resp();
    run_instr(3'd3, 2'd2, 8'hFF, lat, o_reg, o_data, o_err, o_pc, o_carry);
    checks++; if (o_data !== 8'hFF || o_pc !== 8'h00) begin errors++; $display("FAIL xori_pc_wrap: data=%h pc=%h need ff/00", o_data, o_pc); end
    finish_resp();
    run_instr(3'd7, 2'd1, 8'h55, lat, o_reg, o_data, o_err, o_pc, o_carry);
    checks++; if (o_err !== 1'b1 || o_data !== 8'h00) begin errors++; $display("FAIL illegal_err: err=%b data=%h need 1/00", o_err, o_data); end
    checks++; if (o_pc !== 8'h00 || o_reg !== 2'd1 || o_carry !== 1'b0) begin errors++; $display("FAIL illegal_state: pc=%h reg=%0d carry=%b need 00/1/0", o_pc, o_reg, o_carry); end
    finish_resp();
  endtask

  task automatic test_backpressure();
    int lat; logic [1:0] o_reg; logic [7:0] o_data, o_pc; logic o_err, o_carry;
    do_reset();
    run_instr(3'd0, 2'd2, 8'd5, lat, o_reg, o_data, o_err, o_pc, o_carry);
    checks++; if (o_data !== 8'd5) begin errors++; $display("FAIL bp_result: got %0d need 5", o_data); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd5 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%0d in_ready=%b need 1/5/0", i, bus.out_valid, bus.out_data, bus.in_ready);
      end
    end
    finish_resp();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: valid=%b in_ready=%b need 0/1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_reset_mid_exec();
    int lat; logic [1:0] o_reg; logic [7:0] o_data, o_pc; logic o_err, o_carry;
    do_reset();
    run_instr(3'd0, 2'd1, 8'd9, lat, o_reg, o_data, o_err, o_pc, o_carry);
    finish_resp();
    bus.in_op = OP_ADDI; bus.in_reg = REG0; bus.in_imm = 8'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_handshake: valid=%b ready=%b need 0/0", bus.out_valid, bus.in_ready); end
    checks++; if (bus.pc !== 8'd0 || bus.out_data !== 8'd0 || bus.carry !== 1'b0) begin errors++; $display("FAIL midrst_clear: pc=%0d data=%0d carry=%b need 0/0/0", bus.pc, bus.out_data, bus.carry); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_instr(3'd0, 2'd0, 8'd0, lat, o_reg, o_data, o_err, o_pc, o_carry);
    checks++; if (o_data !== 8'd0 || o_pc !== 8'd1) begin errors++; $display("FAIL midrst_reg0: data=%0d pc=%0d need 0/1", o_data, o_pc); end
    finish_resp();
  endtask

  task automatic test_back_to_back();
    int cnt;
    do_reset();
    cnt = 0;
    bus.in_op = OP_ADDI; bus.in_reg = REG0; bus.in_imm = 8'd1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) cnt++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    checks++; if (cnt !== 10) begin errors++; $display("FAIL b2b_throughput: %0d results in 30 cycles need 10", cnt); end
    checks++; if (bus.pc !== 8'd10) begin errors++; $display("FAIL b2b_pc: got %0d need 10", bus.pc); end
  endtask

  task automatic test_random();
    int lat; logic [1:0] o_reg; logic [7:0] o_data, o_pc; logic o_err, o_carry;
    int op, r, imm, hold, e_reg, e_data, e_err;
    do_reset();
    model_reset();
    for (int k = 0; k < 150; k++) begin
      op   = int'($urandom_range(0, 7));
      r    = int'($urandom_range(0, 3));
      imm  = int'($urandom_range(0, 255));
      hold = int'($urandom_range(0, 2));
      run_instr(3'(op), 2'(r), 8'(imm), lat, o_reg, o_data, o_err, o_pc, o_carry);
      model_step(op, r, imm, e_reg, e_data, e_err);
      checks++;
      if (lat !== 2 || o_reg !== 2'(e_reg) || o_data !== 8'(e_data) || o_err !== 1'(e_err) ||
          o_pc !== 8'(m_pc) || o_carry !== m_carry) begin
        errors++;
        $display("FAIL rand[%0d] op=%0d r=%0d imm=%0d: lat=%0d reg=%0d data=%0d err=%b pc=%0d c=%b need lat=2 reg=%0d data=%0d err=%0d pc=%0d c=%b",
                 k, op, r, imm, lat, o_reg, o_data, o_err, o_pc, o_carry, e_reg, e_data, e_err, m_pc, m_carry);
      end
      repeat (hold) begin @(posedge clk); #1; end
      finish_resp();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_ADDI;
    bus.in_reg    = REG0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add_jmpc();
    test_sub_call();
    test_wrap_illegal();
    test_backpressure();
    test_reset_mid_exec();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_exec.md
INSTR_EXEC -- requirements
Module: instr_exec

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the register, immediate and output data width.
REQ-002 Parameter PC_W, default 8, SHALL set the program-counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark a valid instruction on in_op/in_reg/in_imm.
REQ-006 in_ready  output  1  SHALL indicate the block accepts an instruction this cycle.
REQ-007 in_op  input  3  SHALL carry op_t: ADDI=0, SUBI=1, ANDI=2, XORI=3, JMP=4, JMPC=5, CALL=6; 7 is illegal.
REQ-008 in_reg  input  2  SHALL carry reg_t (REG0..REG3), the destination register.
REQ-009 in_imm  input  DATA_W  SHALL carry the immediate operand or jump target.
REQ-010 out_valid  output  1  SHALL mark a valid result on out_reg/out_data/err.
REQ-011 out_ready  input  1  SHALL indicate the consumer takes the result.
REQ-012 out_reg  output  2  SHALL give the register written, or in_reg echoed for JMP/JMPC/illegal.
REQ-013 out_data  output  DATA_W  SHALL give the new register value for ALU ops and CALL, or the new pc for JMP/JMPC.
REQ-014 pc  output  PC_W  SHALL give the current program counter.
REQ-015 carry  output  1  SHALL give the carry/borrow flag.
REQ-016 err  output  1  SHALL be high with out_valid when the instruction was illegal.

Function
REQ-017 FSM SHALL have states IDLE, EXEC, RESP; in_ready=1 only in IDLE.
REQ-018 IDLE: in_valid&in_ready at an edge SHALL latch op/reg/imm and enter EXEC.
REQ-019 EXEC SHALL compute in one cycle and, at the next edge, update registers, pc, carry and output registers, then enter RESP.
REQ-020 out_valid SHALL rise exactly 2 edges after the accepting edge; minimum throughput one instruction per 3 cycles.
REQ-021 RESP: out_valid SHALL stay high and out_reg/out_data/err stable until out_valid&out_ready at an edge, then return to IDLE.
REQ-022 ADDI SHALL write (R+imm) mod 2^DATA_W; carry = carry-out.
REQ-023 SUBI SHALL write (R-imm) mod 2^DATA_W; carry = 1 iff R<imm.
REQ-024 ANDI/XORI SHALL write R&imm / R^imm; carry unchanged.
REQ-025 ALU ops SHALL set pc=pc+1 mod 2^PC_W (255 wraps to 0).
REQ-026 JMP SHALL set pc=imm; no register write; carry unchanged.
REQ-027 JMPC SHALL set pc=imm if carry=1, else pc+1; carry unchanged.
REQ-028 CALL SHALL write REG3=pc+1 (wrapped) and set pc=imm, regardless of in_reg; out_reg=REG3.
REQ-029 Illegal op 7 SHALL change no register, pc or carry; err=1, out_data=0.

Reset
REQ-030 rst_n low SHALL immediately clear REG0..REG3, pc, carry, out_valid, out_reg, out_data, err and force IDLE; in_ready SHALL be 0 while rst_n is low and 1 from the first edge after release.
REQ-031 Reset during EXEC or RESP SHALL drop the pending instruction with no partial state update.

Structure
REQ-032 Package instr_pkg SHALL hold op_t, reg_t and the DATA_W/PC_W defaults.
REQ-033 Combinational sub-module instr_alu SHALL compute result, carry and next pc from op, operand, imm, carry and pc.

Verification
REQ-034 Reset; ADDI REG1 imm=100 -> out_valid 2 edges after accept, out_reg=1, out_data=100, carry=0, pc=1.
REQ-035 Then ADDI REG1 imm=200 -> out_data=44, carry=1; then JMPC imm=0x40 -> out_data=0x40, pc=0x40.
REQ-036 Reset; SUBI REG0 imm=1 -> out_data=255, carry=1; CALL imm=0x10 -> REG3=2, out_reg=3, out_data=2, pc=0x10.
REQ-037 With pc=255, XORI REG2 imm=0xFF -> out_data=0xFF, pc=0; in_op=7 -> err=1, out_data=0, pc unchanged.
REQ-038 Hold out_ready=0 for 5 cycles in RESP -> out_valid/out_data stable, in_ready=0; pull rst_n low mid-EXEC -> outputs 0 immediately, no register written.
